// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the processing-element controller.
package pe_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned N_DEFAULT = 16;

   typedef enum logic [2:0] {
      PeIdle  = 3'd0,
      PeClear = 3'd1,
      PeLoadA = 3'd2,
      PeLoadB = 3'd3,
      PeMac   = 3'd4,
      PeDone  = 3'd5
   } pe_ctrl_state_t;

endpackage

// File: rtl/pe_controller_if.sv
// Command/vector/result handshakes plus the processing-element control bundle.
interface pe_controller_if
   import pe_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) ();

   localparam int unsigned LW = $clog2(N) + 1;
   localparam int unsigned PW = $clog2(N);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [LW-1:0]         cmd_len;
   logic                  vec_valid;
   logic                  vec_ready;
   logic [N*DATA_W-1:0]   vec_data;
   logic                  res_valid;
   logic                  res_ready;
   logic [DATA_W-1:0]     res_data;
   logic                  err;
   logic                  busy;

   logic                  rst_mul;
   logic                  mac_ctrl;
   logic                  inc_pc;
   logic                  mat_mux;
   logic                  write_mat;
   logic [N*DATA_W-1:0]   pe_datain;
   logic [PW-1:0]         pe_pc;
   logic [DATA_W-1:0]     pe_dataout;

   // Controller side.
   modport slave (
      input  cmd_valid, cmd_len, vec_valid, vec_data, res_ready, pe_pc, pe_dataout,
      output cmd_ready, vec_ready, res_valid, res_data, err, busy,
             rst_mul, mac_ctrl, inc_pc, mat_mux, write_mat, pe_datain
   );

   // Host and processing-element side.
   modport master (
      output cmd_valid, cmd_len, vec_valid, vec_data, res_ready, pe_pc, pe_dataout,
      input  cmd_ready, vec_ready, res_valid, res_data, err, busy,
             rst_mul, mac_ctrl, inc_pc, mat_mux, write_mat, pe_datain
   );

endinterface

// File: rtl/pe_controller.sv
// Sequences one dot-product command through a processing element:
// clear, load A, load B, len MAC cycles, then hold the result until consumed.
module pe_controller
   import pe_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   pe_controller_if.slave bus
);

   localparam int unsigned LW = $clog2(N) + 1;
   localparam int unsigned PW = $clog2(N);

   pe_ctrl_state_t state_q, state_d;
   logic [LW-1:0]  len_q, len_d;
   logic [LW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PeIdle;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         PeIdle: begin
            if (bus.cmd_valid) begin
               len_d   = (bus.cmd_len > LW'(N)) ? LW'(N) : bus.cmd_len;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = PeClear;
            end
         end
         PeClear: state_d = PeLoadA;
         PeLoadA: begin
            if (bus.vec_valid) state_d = PeLoadB;
         end
         PeLoadB: begin
            if (bus.vec_valid) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? PeDone : PeMac;
            end
         end
         PeMac: begin
            // Mismatch is only recorded; the sequence still runs to completion.
            if (bus.pe_pc != cnt_q[PW-1:0]) err_d = 1'b1;
            if ((cnt_q + LW'(1)) == len_q) begin
               state_d = PeDone;
            end else begin
               cnt_d = cnt_q + LW'(1);
            end
         end
         PeDone: begin
            if (bus.res_ready) state_d = PeIdle;
         end
         default: state_d = PeIdle;
      endcase
   end

   always_comb begin
      // Ready is withheld while reset is asserted so it only appears after release.
      bus.cmd_ready = (state_q == PeIdle) && rst_n;
      bus.vec_ready = (state_q == PeLoadA) || (state_q == PeLoadB);
      bus.mat_mux   = (state_q == PeLoadA);
      bus.write_mat = bus.vec_ready && bus.vec_valid;
      bus.rst_mul   = (state_q == PeClear);
      bus.mac_ctrl  = (state_q == PeMac);
      bus.inc_pc    = (state_q == PeMac);
      bus.res_valid = (state_q == PeDone);
      bus.res_data  = (state_q == PeDone) ? bus.pe_dataout : '0;
      bus.busy      = (state_q != PeIdle);
      bus.err       = err_q;
   end

   assign bus.pe_datain = bus.vec_data;

endmodule

// File: tb/tb_pe_controller.sv
// Directed bench: drives commands and vectors, models the processing element,
// and checks results, cycle timing, MAC counts, error flag and reset behaviour.
module tb_pe_controller;
   import pe_pkg::*;

   localparam int unsigned N  = 16;
   localparam int unsigned LW = $clog2(N) + 1;
   localparam int unsigned PW = $clog2(N);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   pe_controller_if #(.N(N)) bus ();

   pe_controller #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Processing-element model: two N-element matrices, accumulator and element pointer.
   logic [31:0]   mat_a [N];
   logic [31:0]   mat_b [N];
   logic [31:0]   acc = '0;
   logic [PW-1:0] pc = '0;
   logic          pe_stuck = 1'b0;

   always @(posedge clk) begin
      if (bus.rst_mul) begin
         acc <= '0;
         pc  <= '0;
      end else begin
         if (bus.write_mat) begin
            for (int i = 0; i < N; i++) begin
               if (bus.mat_mux) mat_a[i] <= bus.pe_datain[i*32 +: 32];
               else             mat_b[i] <= bus.pe_datain[i*32 +: 32];
            end
         end
         if (bus.mac_ctrl) acc <= acc + mat_a[pc] * mat_b[pc];
         if (bus.inc_pc)   pc  <= pc + 1'b1;
      end
   end

   assign bus.pe_pc      = pe_stuck ? '0 : pc;
   assign bus.pe_dataout = acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [N*32-1:0] vec_seq(input int start);
      logic [N*32-1:0] v;
      for (int i = 0; i < N; i++) v[i*32 +: 32] = 32'(start + i);
      return v;
   endfunction

   function automatic logic [N*32-1:0] vec_const(input int val);
      logic [N*32-1:0] v;
      for (int i = 0; i < N; i++) v[i*32 +: 32] = 32'(val);
      return v;
   endfunction

   // Full transaction. Cycle count includes the accept edge as edge 1.
   task automatic run_txn(input string name, input int len, input logic [N*32-1:0] a,
                          input logic [N*32-1:0] b, input int gap, input int stall,
                          input int exp_res, input int exp_cyc, input int exp_macs,
                          input int exp_pc, input logic exp_err);
      int cyc;
      int macs;
      int wait_ctr;
      bit a_sent;
      bit hs;
      logic [31:0] res0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LW'(len);
      check({name, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check({name, "_err_clr"}, 32'(bus.err), 32'd0);
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      macs = 0;
      wait_ctr = gap;
      a_sent = 1'b0;
      while (!bus.res_valid && cyc < 200) begin
         if (bus.mac_ctrl) macs++;
         if (bus.vec_ready && wait_ctr > 0) begin
            bus.vec_valid = 1'b0;
            wait_ctr--;
         end else begin
            bus.vec_valid = bus.vec_ready;
            bus.vec_data  = a_sent ? b : a;
         end
         hs = bus.vec_valid && bus.vec_ready;
         @(posedge clk);
         cyc++;
         if (hs) begin
            a_sent   = 1'b1;
            wait_ctr = gap;
         end
         @(negedge clk);
      end
      bus.vec_valid = 1'b0;
      check({name, "_res_valid"}, 32'(bus.res_valid), 32'd1);
      check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
      check({name, "_mac_cycles"}, 32'(macs), 32'(exp_macs));
      check({name, "_res_data"}, bus.res_data, 32'(exp_res));
      check({name, "_err"}, 32'(bus.err), 32'(exp_err));
      check({name, "_pe_pc"}, 32'(pc), 32'(exp_pc));
      check({name, "_no_inc"}, 32'(bus.inc_pc), 32'd0);
      res0 = bus.res_data;
      repeat (stall) begin
         @(negedge clk);
         check({name, "_stall_data"}, bus.res_data, res0);
         check({name, "_stall_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      end
      bus.res_ready = 1'b1;
      check({name, "_hs_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      bus.res_ready = 1'b0;
      check({name, "_idle_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      check({name, "_idle_res_valid"}, 32'(bus.res_valid), 32'd0);
      check({name, "_idle_res_data"}, bus.res_data, 32'd0);
   endtask

   initial begin
      int macs;
      int guard;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.vec_valid = 1'b0;
      bus.vec_data  = '0;
      bus.res_ready = 1'b0;

      #12;
      check("rst_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rel_busy", 32'(bus.busy), 32'd0);
      check("rel_err", 32'(bus.err), 32'd0);
      check("rel_res_valid", 32'(bus.res_valid), 32'd0);
      check("rel_res_data", bus.res_data, 32'd0);
      check("rel_vec_ready", 32'(bus.vec_ready), 32'd0);
      check("rel_rst_mul", 32'(bus.rst_mul), 32'd0);

      // 1*5 + 2*6 + 3*7 + 4*8 = 70
      run_txn("len4", 4, vec_seq(1), vec_seq(5), 0, 0, 70, 8, 4, 4, 1'b0);
      // 16 * (2*3) = 96, pointer wraps to 0
      run_txn("len16", 16, vec_const(2), vec_const(3), 0, 0, 96, 20, 16, 0, 1'b0);
      run_txn("len0", 0, vec_seq(1), vec_seq(1), 0, 0, 0, 4, 0, 0, 1'b0);
      // Length 20 clamps to 16: 16 * (1*2) = 32
      run_txn("clamp", 20, vec_const(1), vec_const(2), 0, 0, 32, 20, 16, 0, 1'b0);
      // 2*1 + 3*2 + 4*3 = 20; each load delayed by 3 idle cycles
      run_txn("stall", 3, vec_seq(2), vec_seq(1), 3, 5, 20, 13, 3, 3, 1'b0);

      // Abort mid-MAC with an asynchronous reset.
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LW'(4);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      macs = 0;
      guard = 0;
      while (macs < 2 && guard < 50) begin
         bus.vec_valid = bus.vec_ready;
         bus.vec_data  = bus.mat_mux ? vec_seq(1) : vec_seq(5);
         @(negedge clk);
         if (bus.mac_ctrl) macs++;
         guard++;
      end
      bus.vec_valid = 1'b0;
      check("abort_reached_mac", 32'(macs), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("abort_mac_ctrl", 32'(bus.mac_ctrl), 32'd0);
      check("abort_inc_pc", 32'(bus.inc_pc), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_res_valid", 32'(bus.res_valid), 32'd0);
      check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("abort_rel_res_valid", 32'(bus.res_valid), 32'd0);
      // 1*4 + 2*5 + 3*6 = 32
      run_txn("after_abort", 3, vec_seq(1), vec_seq(4), 0, 0, 32, 7, 3, 3, 1'b0);

      // Pointer stuck at 0: mismatch flagged from the second MAC cycle onward.
      pe_stuck = 1'b1;
      run_txn("stuck", 4, vec_seq(1), vec_seq(1), 0, 0, 30, 8, 4, 4, 1'b1);
      pe_stuck = 1'b0;
      // The accept of this command must clear the sticky flag.
      run_txn("recover", 2, vec_seq(1), vec_seq(1), 0, 0, 5, 6, 2, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pe_controller.md
PE_CONTROLLER -- requirements
Module: pe_controller

Interface
REQ-001 SHALL have parameter N, default 16, giving vector length in 32-bit elements; it SHALL match the attached processing element.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port CMD_VALID  input  1  command request.
REQ-005 SHALL have port CMD_READY  output  1  command accepted when CMD_VALID && CMD_READY.
REQ-006 SHALL have port CMD_LEN  input  $clog2(N)+1  number of elements to multiply-accumulate.
REQ-007 SHALL have port VEC_VALID  input  1  vector word present.
REQ-008 SHALL have port VEC_READY  output  1  vector word accepted on VEC_VALID && VEC_READY.
REQ-009 SHALL have port VEC_DATA  input  N x 32  packed vector, element 0 in bits [31:0].
REQ-010 SHALL have port RES_VALID  output  1  result available.
REQ-011 SHALL have port RES_READY  input  1  result consumed on RES_VALID && RES_READY.
REQ-012 SHALL have port RES_DATA  output  32  dot-product result.
REQ-013 SHALL have port ERR  output  1  sticky PE counter mismatch flag.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-015 SHALL have PE-side outputs RST_MUL, MAC_CTRL, INC_PC, MAT_MUX, WRITE_MAT (1 bit each) and PE_DATAIN (N x 32); inputs PE_PC ($clog2(N)) and PE_DATAOUT (32).

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, LOAD_A, LOAD_B, MAC, DONE.
REQ-017 IDLE: CMD_READY=1; on accept, capture len = min(CMD_LEN, N), clear ERR, go to CLEAR.
REQ-018 CLEAR: RST_MUL=1 for exactly one cycle; then go to LOAD_A.
REQ-019 LOAD_A: VEC_READY=1, MAT_MUX=1, WRITE_MAT=VEC_VALID; on handshake go to LOAD_B; otherwise wait indefinitely.
REQ-020 LOAD_B: VEC_READY=1, MAT_MUX=0, WRITE_MAT=VEC_VALID; on handshake go to MAC, or to DONE if len==0.
REQ-021 PE_DATAIN SHALL equal VEC_DATA combinationally at all times.
REQ-022 MAC: MAC_CTRL=1 and INC_PC=1 every cycle; internal count cnt runs 0..len-1; after the cycle with cnt==len-1, go to DONE; exactly len MAC cycles.
REQ-023 In each MAC cycle, if PE_PC != cnt, ERR SHALL set and hold until the next command accept; the sequence SHALL still complete normally.
REQ-024 DONE: RES_VALID=1, RES_DATA=PE_DATAOUT (stable because the PE is idle); on RES_READY go to IDLE; RES_DATA SHALL stay stable while stalled.
REQ-025 All PE controls and VEC_READY/RES_VALID/CMD_READY SHALL be 0 outside the states that assert them; RES_DATA SHALL be 0 outside DONE.
REQ-026 With no stalls, RES_VALID SHALL rise len+4 cycles after the command-accept edge.
REQ-027 A new command SHALL NOT be accepted in the same cycle as a result handshake; CMD_READY rises the cycle after DONE exits.
REQ-028 With len==N, PE_PC SHALL wrap to 0 after the final MAC cycle, and no further INC_PC SHALL be issued.

Reset
REQ-029 RSTN low SHALL asynchronously force IDLE, cnt=0, len=0, ERR=0, and all outputs to 0 except CMD_READY, which is 1 after reset release.
REQ-030 Reset mid-operation SHALL abandon the command with no result produced; the PE accumulator is cleared by the next CLEAR.

Structure
REQ-031 Package pe_pkg SHALL hold the state enum pe_ctrl_state_t, DATA_W=32, and the default N.
REQ-032 Single module; no sub-module is required; estimated 150-250 RTL lines.

Verification
REQ-033 len=4, A=[1,2,3,4], B=[5,6,7,8], no stalls -> RES_DATA=70, RES_VALID 8 cycles after accept, ERR=0.
REQ-034 len=16, A all 2, B all 3 -> RES_DATA=96, PE_PC=0 in DONE, 16 MAC_CTRL cycles.
REQ-035 len=0 -> RES_DATA=0, zero MAC_CTRL cycles; CMD_LEN=20 -> clamped to 16 MAC cycles.
REQ-036 VEC_VALID gaps of 3 cycles and RES_READY held low for 5 cycles -> RES_DATA constant, CMD_READY=0 until the cycle after the handshake.
REQ-037 RSTN pulsed low during MAC cycle 2 -> outputs 0 immediately, CMD_READY=1 after release; a subsequent command gives the correct result.
REQ-038 PE model with PE_PC stuck at 0 -> ERR=1 in DONE; ERR cleared at the next command accept.
